// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request port, imem write port, err pulse and occupancy for instr_encoder
interface instr_encoder_if #(
  parameter int ADDR_W = 16,
  parameter int DEPTH = 4
);
  logic in_valid;
  logic in_ready;
  logic [3:0] in_op;
  logic [4:0] in_rd;
  logic [4:0] in_rn;
  logic [4:0] in_rm;
  logic [25:0] in_imm;
  logic imem_valid;
  logic imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic err;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, imem_ready,
    input in_ready, imem_valid, imem_addr, imem_wdata, err, count
  );
  modport slave (
    input in_valid, in_op, in_rd, in_rn, in_rm, in_imm, imem_ready,
    output in_ready, imem_valid, imem_addr, imem_wdata, err, count
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: encodes LEGv8-subset requests into a FIFO drained to sequential imem addresses; ENC_RANGE_CHECK_EN rejects out-of-range immediates
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 16,
  parameter int BASE = 0
) (
  input logic clk,
  input logic reset,
  instr_encoder_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [25:0] imm;
  logic [4:0] rd, rn, rm;
  logic [31:0] word;
  logic op_ok, ok, hs, push, pop;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic err_q, err_d;
  logic [31:0] mem_q [DEPTH];
  assign imm = bus.in_imm;
  assign rd = bus.in_rd;
  assign rn = bus.in_rn;
  assign rm = bus.in_rm;
  assign op_ok = bus.in_op < 4'd11;
  always_comb begin
    word = '0;
    case (bus.in_op)
      4'd0: word = {11'h558, rm, 6'd0, rn, rd};
      4'd1: word = {11'h488, imm[10:0], rn, rd};
      4'd2: word = {11'h450, rm, 6'd0, rn, rd};
      4'd3: word = {11'h758, rm, 6'd0, rn, rd};
      4'd4: word = {11'h7C2, imm[8:0], 2'b00, rn, rd};
      4'd5: word = {11'h7C0, imm[8:0], 2'b00, rn, rd};
      4'd6: word = {6'b000101, imm};
      4'd7: word = {8'hB4, imm[18:0], rd};
      4'd8: word = {8'h54, imm[18:0], 5'b01011};
      4'd9: word = {11'h650, rm, 6'd0, rn, rd};
      4'd10: word = {11'h69B, 5'd0, imm[5:0], rn, rd};
      default: word = '0;
    endcase
  end
`ifdef ENC_RANGE_CHECK_EN
  logic in_range;
  assign in_range = bus.in_op == 4'd1 ? ~|imm[25:11] :
                    (bus.in_op == 4'd4 || bus.in_op == 4'd5) ? (&imm[25:8] | ~|imm[25:8]) :
                    (bus.in_op == 4'd7 || bus.in_op == 4'd8) ? (&imm[25:18] | ~|imm[25:18]) :
                    bus.in_op == 4'd10 ? ~|imm[25:6] : 1'b1;
  assign ok = op_ok & in_range;
`else
  assign ok = op_ok;
`endif
  always_comb begin
    hs = bus.in_valid & bus.in_ready;
    push = hs & ok;
    pop = bus.imem_valid & bus.imem_ready;
    err_d = hs & ~ok;
    wp_d = push ? wp_q + PW'(1) : wp_q;
    rp_d = pop ? rp_q + PW'(1) : rp_q;
    count_d = count_q + CW'(push) - CW'(pop);
    addr_d = pop ? addr_q + ADDR_W'(4) : addr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
      addr_q <= ADDR_W'(BASE);
      err_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      count_q <= count_d;
      addr_q <= addr_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= word;
  end
  assign bus.in_ready = count_q < CW'(DEPTH);
  assign bus.imem_valid = count_q != '0;
  assign bus.imem_wdata = mem_q[rp_q];
  assign bus.imem_addr = addr_q;
  assign bus.err = err_q;
  assign bus.count = count_q;
endmodule
